// File: rtl/wb_queue_pkg.sv
// Shared widths and constants for the register-file write queue.
package wb_queue_pkg;

  localparam int WBQ_AW   = 5;
  localparam int WBQ_DW   = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_HEAD = 2'd2
  } wr_src_e;

endpackage

// File: rtl/wb_queue_fifo.sv
// Storage for queued long-latency results: pointers, count, valid/live bits and
// per-entry address compares against the hazard queries and the WB destination.
module wb_queue_fifo
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WBQ_AW,
  parameter int DW    = WBQ_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  input  logic [DEPTH-1:0]           kill_vec,
  input  logic [AW-1:0]              raddr1,
  input  logic [AW-1:0]              raddr2,
  input  logic [AW-1:0]              pipe_waddr,
  output logic [CW-1:0]              count,
  output logic [PW-1:0]              rd_ptr,
  output logic [AW-1:0]              head_addr,
  output logic                       head_live,
  output logic [DEPTH-1:0][DW-1:0]   entry_data,
  output logic [DEPTH-1:0]           match1_vec,
  output logic [DEPTH-1:0]           match2_vec,
  output logic [DEPTH-1:0]           matchp_vec
);

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0]         live_q;
  logic [PW-1:0]            wr_ptr_q;
  logic [PW-1:0]            rd_ptr_q;
  logic [CW-1:0]            count_q;

  // NOTE: sequential state uses non-blocking assignments only, so later
  // assignments in the same block cleanly override earlier ones at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      live_q   <= '0;
    end else begin
      live_q <= live_q & ~kill_vec;
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        live_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage is not reset; valid/live bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    match1_vec = '0;
    match2_vec = '0;
    matchp_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1_vec[i] = valid_q[i] && live_q[i] && (addr_q[i] == raddr1);
      match2_vec[i] = valid_q[i] && live_q[i] && (addr_q[i] == raddr2);
      matchp_vec[i] = valid_q[i] && live_q[i] && (addr_q[i] == pipe_waddr);
    end
  end

  assign count      = count_q;
  assign rd_ptr     = rd_ptr_q;
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_live  = live_q[rd_ptr_q];
  assign entry_data = data_q;

endmodule

// File: rtl/wb_queue.sv
// Single register-file write port shared by the WB stage and a queued long-latency
// unit, with RAW hazard reporting. Define WBQ_FWD_EN to forward instead of stalling.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WBQ_AW,
  parameter int DW    = WBQ_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_we,
  input  logic [AW-1:0]           pipe_waddr,
  input  logic [DW-1:0]           pipe_wdata,
  input  logic                    lat_valid,
  output logic                    lat_ready,
  input  logic [AW-1:0]           lat_waddr,
  input  logic [DW-1:0]           lat_wdata,
  output logic                    rf_we,
  output logic [AW-1:0]           rf_waddr,
  output logic [DW-1:0]           rf_wdata,
  input  logic [AW-1:0]           raddr1,
  input  logic [AW-1:0]           raddr2,
  output logic                    stall_req,
`ifdef WBQ_FWD_EN
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [DW-1:0]           fwd_data1,
  output logic [DW-1:0]           fwd_data2,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic                     pipe_eff;
  logic                     push;
  logic                     pop;
  logic [DEPTH-1:0]         kill_vec;
  logic [CW-1:0]            fifo_count;
  logic [PW-1:0]            rd_ptr;
  logic [AW-1:0]            head_addr;
  logic                     head_live;
  logic [DEPTH-1:0][DW-1:0] entry_data;
  logic [DEPTH-1:0]         match1_vec;
  logic [DEPTH-1:0]         match2_vec;
  logic [DEPTH-1:0]         matchp_vec;
  logic                     hit1;
  logic                     hit2;
  wr_src_e                  wr_src;

  assign pipe_eff  = pipe_we && (pipe_waddr != ZERO_ADDR);
  assign lat_ready = (fifo_count != CW'(DEPTH));
  // Results for r0 complete the handshake but are never stored.
  assign push      = lat_valid && lat_ready && (lat_waddr != ZERO_ADDR);
  assign pop       = !pipe_eff && (fifo_count != '0);
  // The WB write is newer than anything queued for the same register.
  assign kill_vec  = pipe_eff ? matchp_vec : '0;

  wb_queue_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (lat_waddr),
    .push_data  (lat_wdata),
    .pop        (pop),
    .kill_vec   (kill_vec),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .pipe_waddr (pipe_waddr),
    .count      (fifo_count),
    .rd_ptr     (rd_ptr),
    .head_addr  (head_addr),
    .head_live  (head_live),
    .entry_data (entry_data),
    .match1_vec (match1_vec),
    .match2_vec (match2_vec),
    .matchp_vec (matchp_vec)
  );

  always_comb begin
    if (pipe_eff)                wr_src = SRC_PIPE;
    else if (fifo_count != '0)   wr_src = SRC_HEAD;
    else                         wr_src = SRC_NONE;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (wr_src)
      SRC_PIPE: begin
        rf_we    = 1'b1;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
      end
      SRC_HEAD: begin
        rf_we    = head_live;
        rf_waddr = head_addr;
        rf_wdata = entry_data[rd_ptr];
      end
      default: ;
    endcase
  end

  // A head draining this cycle still counts: the register file does not bypass.
  assign hit1 = (raddr1 != ZERO_ADDR) && (|match1_vec);
  assign hit2 = (raddr2 != ZERO_ADDR) && (|match2_vec);

`ifdef WBQ_FWD_EN
  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (match1_vec[idx]) fwd_data1 = entry_data[idx];
      if (match2_vec[idx]) fwd_data2 = entry_data[idx];
    end
  end

  assign fwd_hit1  = hit1;
  assign fwd_hit2  = hit2;
  assign stall_req = 1'b0;
`else
  assign stall_req = hit1 || hit2;
`endif

  assign count = fifo_count;

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Writer side of the register file's single write port.
- Merges two producers onto one write port:
  - the in-order WB stage, which cannot stall;
  - a long-latency unit (divider / miss-load return) over a valid/ready handshake.
- Long-latency results wait in a small FIFO and drain in cycles with no WB write.
- Also reports read-after-write hazards on queued registers so decode can stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- pipe_we  in  1  WB-stage write enable.
- pipe_waddr  in  AW  WB-stage destination register.
- pipe_wdata  in  DW  WB-stage write data.
- lat_valid  in  1  long-latency result valid.
- lat_ready  out  1  queue can accept a result.
- lat_waddr  in  AW  long-latency destination register.
- lat_wdata  in  DW  long-latency result data.
- rf_we  out  1  register file write enable.
- rf_waddr  out  AW  register file write address.
- rf_wdata  out  DW  register file write data.
- raddr1  in  AW  decode read address 1 (hazard query).
- raddr2  in  AW  decode read address 2 (hazard query).
- stall_req  out  1  decode must stall this cycle.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset is asynchronous on rst high: read/write pointers 0, all entry valid/live bits 0, count 0. Reset abandons queued results.
- Entry contents: waddr, wdata, live.
- Handshake:
  - lat_ready = (count != DEPTH). It is combinational from state only and never depends on lat_valid.
  - A result is accepted on a clock edge with lat_valid && lat_ready.
  - An accepted result with lat_waddr == 0 is dropped: not enqueued, count unchanged.
- Write port (combinational mux, zero latency):
  - pipe_eff = pipe_we && pipe_waddr != 0.
  - If pipe_eff: rf_we=1, rf_waddr=pipe_waddr, rf_wdata=pipe_wdata. FIFO does not pop.
  - Else if count != 0: the head pops on the edge. rf_we = head.live, address/data from the head.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- WAW kill:
  - When pipe_eff, every queued entry with waddr == pipe_waddr clears live on the edge; the WB write is newer.
  - The kill does not apply to an entry enqueued in the same cycle.
  - A dead entry still pops in a free cycle with rf_we=0.
- Simultaneous enqueue and pop in the same cycle:
  - Both happen; count is unchanged.
  - When full, lat_ready=0 even if a pop occurs that cycle.
- Ordering: the FIFO drains strictly oldest first. WB always has priority; a continuous WB stream starves the queue indefinitely. This is accepted.
- Hazard:
  - hitN = raddrN != 0 && some valid, live entry has waddr == raddrN.
  - stall_req = hit1 || hit2.
  - The head being written this cycle still counts as a hit; the register file does not forward from this block.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.

Optional Feature:
- Macro: WBQ_FWD_EN.
- Defined:
  - Adds ports fwd_hit1/fwd_hit2 (out, 1) and fwd_data1/fwd_data2 (out, DW).
  - fwd_dataN is the wdata of the youngest valid, live entry matching raddrN; fwd_hitN = hitN.
  - stall_req is tied to 0. Decode muxes fwd data below the ex/mem/wb bypasses.
- Undefined: these ports are absent and stall_req behaves as above.

Decomposition:
- Shared package/defines header: AW, DW, and the zero-register constant. Reuse the existing defines.vh include.
- One natural sub-module: wb_queue_fifo.
  - Contains storage, pointers, count, live bits, and per-entry address compare vectors.
  - Exports match_vec for raddr1, raddr2 and pipe_waddr.
- The top level holds the port mux, kill logic, hazard/forward reduction and youngest-match priority.

Test Plan:
- Single drain: idle WB; enqueue (r5, 0xDEADBEEF) → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; count returns 0.
- WB priority: enqueue r3, then hold pipe_we to r7 for 3 cycles → rf_waddr=7 for 3 cycles, then r3 drains on cycle 4; stall_req=1 for raddr1=3 until the drain edge.
- Full: with DEPTH=4 and WB busy, enqueue 4 results → lat_ready=0, a 5th lat_valid is held. Free one cycle → pop, lat_ready=1 next cycle.
- WAW kill: queue (r9, 0x11), then pipe writes (r9, 0x22) → later drain cycle rf_we=0; register 9 keeps 0x22; stall_req for r9 clears.
- r0 and simultaneity:
  - lat write to r0 → count stays 0.
  - Enqueue while the head pops → count unchanged, data order preserved.
- Reset mid-operation: 3 entries queued, assert rst → count=0, lat_ready=1, rf_we=0, stall_req=0 immediately. With WBQ_FWD_EN: two entries for r4 (0x1, then 0x2) → fwd_data1=0x2.
